// File: rtl/tdm_demux4_b4_pkg.sv
// Shared definitions for the 4-slot TDM receive demultiplexer.
package tdm_demux4_b4_pkg;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_b4_if.sv
// Bus bundle between the TDM word source and the demultiplexer's channel outputs.
interface tdm_demux4_b4_if #(
  parameter int unsigned WIDTH = 4
);
  import tdm_demux4_b4_pkg::*;

  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              sof;
  logic [WIDTH-1:0]  o0;
  logic [WIDTH-1:0]  o1;
  logic [WIDTH-1:0]  o2;
  logic [WIDTH-1:0]  o3;
  logic              frame_valid;
  logic              frame_err;
  logic              locked;
  logic [SLOT_W-1:0] slot;

  modport master (
    output din, din_valid, sof,
    input  o0, o1, o2, o3, frame_valid, frame_err, locked, slot
  );

  modport slave (
    input  din, din_valid, sof,
    output o0, o1, o2, o3, frame_valid, frame_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux4_b4_dec2to4.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4_b4.sv
// TDM word stream to four double-buffered channel registers; frames commit atomically.
module tdm_demux4_b4
  import tdm_demux4_b4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux4_b4_if.slave  bus
);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]  shadow_q [NUM_SLOTS-1];
  logic [WIDTH-1:0]  shadow_d [NUM_SLOTS-1];
  logic [WIDTH-1:0]  o_q [NUM_SLOTS];
  logic [WIDTH-1:0]  o_d [NUM_SLOTS];
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  logic [SLOT_W-1:0] ld_sel;
  logic              ld_en;
  logic [3:0]        ld;

  // sof always targets slot 0; decoder line 3 doubles as the commit strobe
  assign ld_sel = bus.sof ? '0 : slot_q;
  assign ld_en  = bus.din_valid & (bus.sof | ((state_q == ST_RECV) & (slot_q != '0)));

  dec2to4 u_dec (
    .sel (ld_sel),
    .en  (ld_en),
    .y   (ld)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    o_d           = o_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
      if (ld[i]) shadow_d[i] = bus.din;
    end

    if (ld[3]) begin
      o_d[0]        = shadow_q[0];
      o_d[1]        = shadow_q[1];
      o_d[2]        = shadow_q[2];
      o_d[3]        = bus.din;
      frame_valid_d = 1'b1;
    end

    if (bus.din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.sof) begin
            state_d = ST_RECV;
            slot_d  = SLOT_W'(1);
          end
        end
        ST_RECV: begin
          if (bus.sof) begin
            slot_d      = SLOT_W'(1);
            frame_err_d = (slot_q != '0);
          end else if (slot_q == '0) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      slot_q        <= '0;
      shadow_q      <= '{default: '0};
      o_q           <= '{default: '0};
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      o_q           <= o_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.o0          = o_q[0];
  assign bus.o1          = o_q[1];
  assign bus.o2          = o_q[2];
  assign bus.o3          = o_q[3];
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.locked      = (state_q == ST_RECV);
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4_b4.sv
// Directed-vector bench for tdm_demux4_b4 with hand-computed expectations.
module tb_tdm_demux4_b4;

  logic clk;
  logic rst;
  int unsigned n_tests;
  int unsigned n_fail;

  tdm_demux4_b4_if #(.WIDTH(4)) bus ();

  tdm_demux4_b4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs, then step to just after the capturing edge
  task automatic cyc(input logic v, input logic s, input logic [3:0] d);
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {bus.o0, bus.o1, bus.o2, bus.o3};
  endfunction

  // flags packed as {frame_valid, frame_err, locked, slot[1:0]}
  function automatic logic [4:0] flags();
    return {bus.frame_valid, bus.frame_err, bus.locked, bus.slot};
  endfunction

  initial begin
    logic [15:0] frame_a [4];
    logic [15:0] exp_o;
    int unsigned pulses;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.din = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'h0000);
    check("reset_flags", 32'(flags()), 32'h00);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 4'h0);
    check("idle_flags", 32'(flags()), 32'h00);

    // basic frame A,1,2,3
    cyc(1'b1, 1'b1, 4'hA);
    check("f1_w0_flags", 32'(flags()), {27'd0, 5'b00101});
    cyc(1'b1, 1'b0, 4'h1);
    cyc(1'b1, 1'b0, 4'h2);
    check("f1_w2_flags", 32'(flags()), {27'd0, 5'b00111});
    check("f1_w2_outs", 32'(outs()), 32'h0000);
    cyc(1'b1, 1'b0, 4'h3);
    check("f1_commit_outs", 32'(outs()), 32'hA123);
    check("f1_commit_flags", 32'(flags()), {27'd0, 5'b10100});
    cyc(1'b0, 1'b0, 4'hF);
    check("f1_pulse_end", 32'(flags()), {27'd0, 5'b00100});
    check("f1_hold", 32'(outs()), 32'hA123);

    // back-to-back frames 5678 then 9ABC
    frame_a[0] = 16'h5678;
    frame_a[1] = 16'h9ABC;
    exp_o  = 16'hA123;
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 4; w++) begin
        logic [15:0] fw;
        fw = frame_a[f];
        cyc(1'b1, (w == 0), fw[15-4*w -: 4]);
        if (w == 3) exp_o = fw;
        if (bus.frame_valid) pulses++;
        check("b2b_outs", 32'(outs()), 32'(exp_o));
        check("b2b_fv", 32'(bus.frame_valid), 32'(w == 3));
      end
    end
    check("b2b_pulses", pulses, 2);

    // resync: sof on slot 2 with F
    cyc(1'b1, 1'b1, 4'h0);
    cyc(1'b1, 1'b0, 4'h1);
    cyc(1'b1, 1'b1, 4'hF);
    check("resync_flags", 32'(flags()), {27'd0, 5'b01101});
    check("resync_hold", 32'(outs()), 32'h9ABC);
    cyc(1'b1, 1'b0, 4'h1);
    check("resync_err_end", 32'(bus.frame_err), 32'h0);
    cyc(1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b0, 4'h3);
    check("resync_commit", 32'(outs()), 32'hF123);
    check("resync_fv", 32'(flags()), {27'd0, 5'b10100});

    // slot 0 without sof drops lock; HUNT drops words
    cyc(1'b1, 1'b0, 4'h7);
    check("unlock_flags", 32'(flags()), {27'd0, 5'b01000});
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 4'h7);
      check("hunt_flags", 32'(flags()), 32'h00);
    end
    check("hunt_hold", 32'(outs()), 32'hF123);

    // gapped frame 4,3,2,1
    pulses = 0;
    for (int w = 0; w < 4; w++) begin
      logic [15:0] fw;
      fw = 16'h4321;
      cyc(1'b1, (w == 0), fw[15-4*w -: 4]);
      if (bus.frame_valid) pulses++;
      if (w < 3) begin
        check("gap_hold", 32'(outs()), 32'hF123);
        cyc(1'b0, 1'b1, 4'hE);
        if (bus.frame_valid) pulses++;
        check("gap_slot", 32'(bus.slot), 32'(w + 1));
      end
    end
    check("gap_outs", 32'(outs()), 32'h4321);
    cyc(1'b0, 1'b0, 4'h0);
    check("gap_pulses", pulses, 1);

    // mid-frame asynchronous reset
    cyc(1'b1, 1'b1, 4'h5);
    cyc(1'b1, 1'b0, 4'h6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_outs", 32'(outs()), 32'h0000);
    check("arst_flags", 32'(flags()), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 4'h0);
    check("post_rst_flags", 32'(flags()), 32'h00);
    cyc(1'b1, 1'b0, 4'h9);
    check("post_rst_hunt", 32'(flags()), 32'h00);
    cyc(1'b1, 1'b1, 4'h1);
    cyc(1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b0, 4'h3);
    cyc(1'b1, 1'b0, 4'h4);
    check("post_rst_frame", 32'(outs()), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
